// File: rtl/pipe_pkg.sv
// Shared EX/MEM field widths and offsets, with helpers that pack the control and data fields.
// Combinational helpers only: no latency and no backpressure.
package pipe_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_W       = 2;
    localparam int M_W        = 3;

    localparam int EXMEM_CTRL_W = WB_W + M_W;
    localparam int EXMEM_DATA_W = 2 * WORD_W + REG_ADDR_W;

    localparam int CTRL_M_LSB     = 0;
    localparam int CTRL_WB_LSB    = M_W;
    localparam int DATA_RD_LSB    = 0;
    localparam int DATA_STORE_LSB = REG_ADDR_W;
    localparam int DATA_ALU_LSB   = REG_ADDR_W + WORD_W;

    function automatic logic [EXMEM_CTRL_W-1:0] pack_exmem_ctrl(
        input logic [WB_W-1:0] wb,
        input logic [M_W-1:0]  m
    );
        logic [EXMEM_CTRL_W-1:0] c;
        c = '0;
        c[CTRL_WB_LSB +: WB_W] = wb;
        c[CTRL_M_LSB +: M_W]   = m;
        return c;
    endfunction

    function automatic logic [EXMEM_DATA_W-1:0] pack_exmem_data(
        input logic [WORD_W-1:0]     alu,
        input logic [WORD_W-1:0]     store,
        input logic [REG_ADDR_W-1:0] rd
    );
        logic [EXMEM_DATA_W-1:0] d;
        d = '0;
        d[DATA_ALU_LSB +: WORD_W]       = alu;
        d[DATA_STORE_LSB +: WORD_W]     = store;
        d[DATA_RD_LSB +: REG_ADDR_W]    = rd;
        return d;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot register (valid/ctrl/data) clocked on the falling edge.
// Latency: one edge. Backpressure: holds when neither load nor clear is asserted.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_valid,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    input  logic              clear,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Clear beats load so a flush also discards whatever was arriving; data is kept.
    always_ff @(negedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= load_valid;
            ctrl  <= load_valid ? load_ctrl : '0;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-slot inter-stage register with flush, bubble insertion and occupancy count.
// Latency: DEPTH falling edges. Backpressure: combinational ready chain, full rate when out_ready=1.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DEPTH  = 1,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    localparam int HEAD = DEPTH - 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [DEPTH-1:0]  slot_valid;
    logic [DEPTH-1:0]  slot_move;
    logic [DEPTH-1:0]  slot_load;
    logic [DEPTH-1:0]  slot_clear;
    logic [DEPTH-1:0]  load_valid;
    logic [CTRL_W-1:0] slot_ctrl [DEPTH];
    logic [DATA_W-1:0] slot_data [DEPTH];
    logic [CTRL_W-1:0] load_ctrl [DEPTH];
    logic [DATA_W-1:0] load_data [DEPTH];
    logic              tail_free;
    logic              accept;
    logic              accept_entry;
    logic              head_adv;

    // Walk from head to tail: a slot moves when its successor is free this cycle.
    always_comb begin : free_chain
        logic succ_free;
        succ_free = out_ready;
        slot_move = '0;
        for (int i = HEAD; i >= 0; i--) begin
            slot_move[i] = slot_valid[i] & succ_free;
            succ_free    = ~slot_valid[i] | slot_move[i];
        end
        tail_free = succ_free;
    end

    assign in_ready     = tail_free & ~flush;
    assign accept       = in_valid & in_ready;
    assign accept_entry = accept & ~bubble;
    assign head_adv     = slot_valid[HEAD] & out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_tail
            assign slot_load[i]  = accept;
            assign load_valid[i] = ~bubble;
            assign load_ctrl[i]  = in_ctrl;
            assign load_data[i]  = in_data;
        end else begin : g_body
            assign slot_load[i]  = slot_move[i-1];
            assign load_valid[i] = 1'b1;
            assign load_ctrl[i]  = slot_ctrl[i-1];
            assign load_data[i]  = slot_data[i-1];
        end

        assign slot_clear[i] = flush | (slot_move[i] & ~slot_load[i]);

        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .load       (slot_load[i]),
            .load_valid (load_valid[i]),
            .load_ctrl  (load_ctrl[i]),
            .load_data  (load_data[i]),
            .clear      (slot_clear[i]),
            .valid      (slot_valid[i]),
            .ctrl       (slot_ctrl[i]),
            .data       (slot_data[i])
        );
    end

    assign out_valid = slot_valid[HEAD];
    assign out_ctrl  = slot_ctrl[HEAD];
    assign out_data  = slot_data[HEAD];

    always_ff @(negedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else if (accept_entry && !head_adv) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (head_adv && !accept_entry) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            assert (occupancy <= DEPTH_OCC);
            assert (!(head_adv && occupancy == '0));
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain at DEPTH 1..4 with shared stimulus and hand-computed expectations.
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    localparam int CW = EXMEM_CTRL_W;
    localparam int DW = EXMEM_DATA_W;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          bubble    = 1'b0;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl   = '0;
    logic [DW-1:0] in_data   = '0;

    logic          rdy1, vld1, rdy2, vld2, rdy3, vld3, rdy4, vld4;
    logic [CW-1:0] ctl1, ctl2, ctl3, ctl4;
    logic [DW-1:0] dat1, dat2, dat3, dat4;
    logic [0:0]    occ1;
    logic [1:0]    occ2, occ3;
    logic [2:0]    occ4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl),
        .in_data(in_data), .bubble(bubble), .flush(flush), .out_valid(vld1),
        .out_ready(out_ready), .out_ctrl(ctl1), .out_data(dat1), .occupancy(occ1));

    pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_ctrl(in_ctrl),
        .in_data(in_data), .bubble(bubble), .flush(flush), .out_valid(vld2),
        .out_ready(out_ready), .out_ctrl(ctl2), .out_data(dat2), .occupancy(occ2));

    pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3), .in_ctrl(in_ctrl),
        .in_data(in_data), .bubble(bubble), .flush(flush), .out_valid(vld3),
        .out_ready(out_ready), .out_ctrl(ctl3), .out_data(dat3), .occupancy(occ3));

    pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy4), .in_ctrl(in_ctrl),
        .in_data(in_data), .bubble(bubble), .flush(flush), .out_valid(vld4),
        .out_ready(out_ready), .out_ctrl(ctl4), .out_data(dat4), .occupancy(occ4));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // State changes on the falling edge; sample 1 time unit afterwards.
    task automatic fall();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        fall();
        reset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] bub_data;

        // Reset held for two edges while upstream drives a full-ones control field.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 5'h1F;
        in_data  = DW'('h1ABC);
        fall();
        fall();
        check("rst_vld", vld1, 1'b0);
        check("rst_ctl", ctl1, '0);
        check("rst_dat", dat1, '0);
        check("rst_occ", occ1, '0);
        check("rst_occ_d4", occ4, '0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_rdy", rdy1, 1'b1);

        // Streaming through DEPTH=3: 1..8 on consecutive edges.
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (n < 8) begin
                in_valid = 1'b1;
                in_data  = DW'(n + 1);
                in_ctrl  = CW'(n + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (n < 8) check("str_rdy", rdy3, 1'b1);
            fall();
            if (n >= 2) begin
                check("str_vld", vld3, 1'b1);
                check("str_dat", dat3, n - 1);
                check("str_ctl", ctl3, n - 1);
            end else begin
                check("str_lat", vld3, 1'b0);
            end
            if (n >= 2 && n <= 7) check("str_occ", occ3, 3);
        end

        // Backpressure on DEPTH=2.
        do_reset();
        in_valid = 1'b1;
        in_data  = DW'('h11);
        in_ctrl  = CW'(1);
        fall();
        in_data = DW'('h22);
        in_ctrl = CW'(2);
        fall();
        in_data = DW'('h33);
        in_ctrl = CW'(3);
        for (int n = 0; n < 4; n++) begin
            #1;
            check("bp_rdy", rdy2, 1'b0);
            check("bp_head", dat2, 'h11);
            check("bp_occ", occ2, 2);
            fall();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_first", dat2, 'h11);
        fall();
        check("bp_second", dat2, 'h22);
        check("bp_occ1", occ2, 1);
        fall();
        check("bp_empty", vld2, 1'b0);
        check("bp_occ0", occ2, 0);
        check("bp_hold", dat2, 'h22);

        // Flush on a full DEPTH=3 chain with simultaneous push and consume.
        do_reset();
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            in_data = DW'('hA1 + n);
            in_ctrl = CW'('h11 + n);
            fall();
        end
        in_data = DW'('hFF);
        in_ctrl = CW'('h1F);
        #1;
        check("fl_full_rdy", rdy3, 1'b0);
        check("fl_full_occ", occ3, 3);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("fl_rdy", rdy3, 1'b0);
        check("fl_head_vld", vld3, 1'b1);
        check("fl_head_dat", dat3, 'hA1);
        check("fl_head_ctl", ctl3, 'h11);
        fall();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("fl_occ", occ3, 0);
        check("fl_vld", vld3, 1'b0);
        check("fl_ctl", ctl3, 0);
        check("fl_dat_hold", dat3, 'hA1);
        fall();
        check("fl_after", vld3, 1'b0);

        // Bubble on DEPTH=1: control dropped, data still captured.
        do_reset();
        bub_data  = {32'h1234_5678, 32'hCAFE_F00D, 5'd9};
        in_valid  = 1'b1;
        bubble    = 1'b1;
        in_ctrl   = pack_exmem_ctrl(2'b10, 3'b101);
        in_data   = pack_exmem_data(32'h1234_5678, 32'hCAFE_F00D, 5'd9);
        out_ready = 1'b1;
        #1;
        check("bub_rdy", rdy1, 1'b1);
        fall();
        bubble   = 1'b0;
        in_valid = 1'b0;
        #1;
        check("bub_vld", vld1, 1'b0);
        check("bub_ctl", ctl1, 0);
        check("bub_occ", occ1, 0);
        check("bub_dat", dat1, bub_data);

        // Reset during a full stall on DEPTH=4, then latency of the first new entry.
        do_reset();
        in_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in_data = DW'('h41 + n);
            in_ctrl = CW'(n + 1);
            fall();
        end
        in_data = DW'('h99);
        #1;
        check("rs_full_occ", occ4, 4);
        check("rs_full_rdy", rdy4, 1'b0);
        check("rs_full_head", dat4, 'h41);
        reset = 1'b1;
        fall();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rs_vld", vld4, 1'b0);
        check("rs_occ", occ4, 0);
        check("rs_dat", dat4, 0);
        check("rs_ctl", ctl4, 0);
        in_valid  = 1'b1;
        in_data   = DW'('h55);
        in_ctrl   = CW'('h15);
        out_ready = 1'b1;
        fall();
        in_valid = 1'b0;
        for (int n = 1; n < 4; n++) begin
            check("rs_lat_early", vld4, 1'b0);
            fall();
        end
        check("rs_lat_vld", vld4, 1'b1);
        check("rs_lat_dat", dat4, 'h55);
        check("rs_lat_ctl", ctl4, 'h15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised elastic pipeline register: a chain of DEPTH slots carrying a control field and a data field between two processor stages.
- Generalises the fixed-width, always-advancing inter-stage registers. Adds valid/ready backpressure (stall), flush, bubble insertion with control-field zeroing, and an occupancy count.
- Used between EX and MEM, or any stage pair. Control bits (write enables) must never leak from an invalid slot.

Parameters:
- DATA_W, 69, payload data width (ALU result 32 + store data 32 + dest reg 5).
- CTRL_W, 5, control field width (WB 2 + M 3); forced to zero whenever a slot is invalid.
- DEPTH, 1, number of register slots in the chain; legal range 1..4.
- OCC_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the falling edge of clk, as for the existing pipeline registers.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a valid entry.
- in_ready  output  1  chain accepts the entry this cycle.
- in_ctrl  input  CTRL_W  control field of the entry.
- in_data  input  DATA_W  data field of the entry.
- bubble  input  1  hazard unit: accept the entry as an invalid slot (control zeroed).
- flush  input  1  kill all entries held in the chain.
- out_valid  output  1  head slot holds a valid entry.
- out_ready  input  1  downstream consumes the head entry.
- out_ctrl  output  CTRL_W  head control field; 0 when out_valid=0.
- out_data  output  DATA_W  head data field; holds its last value when invalid.
- occupancy  output  OCC_W  number of valid slots.

Behaviour:
- Reset (reset=1 sampled on the falling edge):
  - all slot valid bits = 0; all ctrl = 0; all data = 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - Reset wins over flush, bubble and any handshake, including mid-transfer.
- Slot indexing: slot 0 is the tail (input side); slot DEPTH-1 is the head (output side).
- Per-slot advance:
  - head_adv = out_valid & out_ready.
  - Slot i is free to load when it is invalid, or when slot i+1 (or the head consumer) advances this same cycle.
  - The ready path is combinational back through the chain; there is no bubble penalty and full throughput is one entry per cycle.
- Input acceptance:
  - in_ready = tail slot free & !flush.
  - On in_valid & in_ready, the tail loads {in_ctrl, in_data} with valid=1.
  - If bubble=1 as well, the tail loads valid=0, ctrl=0, and in_data still captured.
- Internal moves: a valid slot whose successor is free moves forward; the vacated slot becomes invalid unless it is refilled the same cycle.
- Latency: an accepted entry reaches out_valid DEPTH falling edges later when there is no backpressure.
- Stall: out_ready=0 with all slots valid gives in_ready=0; every slot holds its ctrl/data unchanged.
- Flush:
  - All valid bits and all ctrl fields clear on the next edge; data fields hold.
  - in_ready=0 during flush, so a simultaneous input is discarded.
  - A simultaneous head_adv still counts as consumed this cycle; the downstream observes it as a normal transfer.
- Occupancy:
  - Registered; +1 on a valid accept, -1 on head_adv, unchanged when both happen.
  - 0 after flush or reset.
  - Never exceeds DEPTH and never underflows (assertion).
- Boundaries:
  - Full and consuming: a simultaneous accept is allowed, occupancy holds at DEPTH.
  - Empty: out_ready is ignored.
  - DEPTH=1 degenerates to a single register with backpressure.
- Invariants (bench assertions):
  - out_ctrl != 0 implies out_valid.
  - Entries leave in acceptance order.
  - No entry is duplicated or dropped except by flush or bubble.

Decomposition:
- Shared package pipe_pkg:
  - constants WORD_W=32, REG_ADDR_W=5, WB_W=2, M_W=3.
  - localparams EXMEM_CTRL_W=WB_W+M_W and EXMEM_DATA_W=2*WORD_W+REG_ADDR_W.
  - field-offset constants for packing/unpacking ctrl and data.
- Sub-module pipe_slot:
  - one valid/ctrl/data register.
  - inputs load, load_valid, clear; outputs valid, ctrl, data.
  - pipe_stage_chain instantiates it DEPTH times in a generate loop and computes the free/advance chain.

Test Plan:
1. Reset: hold reset=1 for 2 edges with in_valid=1, in_ctrl=5'h1F -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 after release.
2. Streaming, DEPTH=3, out_ready=1: push data 1..8 on consecutive edges -> out_data 1..8 in order starting at the 3rd edge after the first accept, no gaps, occupancy steady at 3.
3. Backpressure, DEPTH=2: fill with A=0x11, B=0x22, drop out_ready for 4 edges -> in_ready=0, head holds 0x11, occupancy=2; release -> 0x11 then 0x22.
4. Flush with simultaneous push and consume, DEPTH=3 full: flush=1, in_valid=1, out_ready=1 -> head entry consumed, new entry discarded, next edge occupancy=0, out_valid=0, out_ctrl=0.
5. Bubble: push ctrl=5'b10101 with bubble=1, DEPTH=1 -> next edge out_valid=0, out_ctrl=0, occupancy=0, out_data=pushed data.
6. Reset mid-stall, DEPTH=4 full with out_ready=0: assert reset 1 edge -> all cleared; first push afterwards emerges after exactly 4 edges.
